booth_mul_arbiter: RTL and testbench
====================================

// Module: booth_mul_arbiter
// PURPOSE
//  Shares one 8x8 signed radix-4 Booth multiplier (8-bit bus: begin/end, operand and result bytes) among NREQ requesters.
//  Round-robin arbiter plus sequencer: grants one requester, drives Q then M onto the multiplier bus, collects the
//  16-bit product (high byte, then low byte), returns it to the owner. A watchdog recovers a hung multiplier.
// PARAMETERS
//  NREQ     4   number of requesters, 2..8
//  TIMEOUT  31  max cycles in WAIT before recovery, 1..255
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_i        in   1        async reset, active low
//  req_i        in   NREQ     request per requester; hold high until own done_o
//  opa_i        in   8*NREQ   multiplier Q per requester, slice k = [8k+7:8k], two's complement
//  opb_i        in   8*NREQ   multiplicand M per requester, same slicing
//  gnt_o        out  NREQ     one-hot current owner, 0 when idle
//  done_o       out  NREQ     1-cycle completion pulse to owner
//  result_o     out  16       signed product, valid with done_o, held until next done_o
//  err_o        out  1        1-cycle pulse with done_o when the op timed out (result_o = 0)
//  mul_rst_no   out  1        active-low reset to multiplier, driven low only in RECOVER
//  mul_begin_o  out  1        start strobe to multiplier
//  mul_inbus_o  out  8        operand bus to multiplier
//  mul_end_i    in   1        multiplier end flag; low result byte is valid in the same cycle
//  mul_outbus_i in   8        multiplier result bus; high byte is valid one cycle before end
// BEHAVIOUR
//  Reset: state IDLE, gnt_o=0, done_o=0, result_o=0, err_o=0, mul_begin_o=0, mul_inbus_o=0, mul_rst_no=1,
//   rr pointer=0, watchdog=0. All outputs are registered.
//  FSM:
//   IDLE: if |req_i -> pick the first set req at or after rr pointer (wrapping NREQ-1 -> 0); latch index and
//    operands; set gnt_o; go LOAD_Q. Otherwise stay.
//   LOAD_Q: mul_begin_o=1, mul_inbus_o=Q (one cycle); go LOAD_M.
//   LOAD_M: mul_begin_o=0, mul_inbus_o=M (one cycle); clear watchdog; go WAIT.
//   WAIT: capture mul_outbus_i every cycle into hi_q; watchdog++.
//    - mul_end_i=1: result_o={hi_q, mul_outbus_i}; go DONE.
//    - watchdog==TIMEOUT and no end: go RECOVER.
//    - End on the timeout cycle counts as success.
//   DONE: done_o[idx]=1 for one cycle; gnt_o=0; rr pointer=(idx+1) mod NREQ; go IDLE.
//    Earliest re-grant is the cycle after DONE.
//   RECOVER: mul_rst_no=0 for 2 cycles; then result_o=0, err_o=1, done_o[idx]=1 for one cycle;
//    rr pointer advances as in DONE; go IDLE.
//  Latency from grant to done_o: 3 + multiplier cycles. Total cycles in WAIT are bounded by TIMEOUT+1.
//  Operands are latched at grant. req_i changes during the op are ignored; done_o is still delivered.
//  Requests arriving during an op wait; there is no queue beyond req_i.
//  mul_begin_o is never asserted while the FSM is outside LOAD_Q. mul_inbus_o holds its last value otherwise.
//  A non-owner never sees done_o. gnt_o is one-hot or zero at all times.
//  rst_i mid-op: immediate return to reset values; no done_o is emitted for the aborted op.
// STRUCTURE
//  Shared package (booth_pkg):
//   - state encoding localparams: IDLE, LOAD_Q, LOAD_M, WAIT, DONE, RECOVER
//   - MUL_W=8, RES_W=16
//  One sub-module: rr_arbiter (NREQ req, pointer in -> one-hot grant + index; combinational).
//  FSM, operand latch, watchdog and result assembly stay in the top module.
// TESTING (bench includes a behavioural multiplier model with configurable latency/hang)
//  1 Reset: hold rst_i=0 with random inputs -> all outputs at reset values, mul_rst_no=1.
//  2 Single op, requester 1: Q=0xFD (-3), M=0x05 -> gnt_o=0010, begin with inbus=0xFD, then 0x05;
//    done_o=0010, result_o=0xFFF1, err_o=0.
//  3 Contention: req_i=0101 together, Q=0x80 M=0x80 (req 0), Q=0x7F M=0x02 (req 2)
//    -> req 0 served first (0x4000), then req 2 (0x00FE); no overlap of gnt_o.
//  4 Wrap/fairness: pointer=3, req_i=1001 held, 4 ops -> grant order 3,0,3,0.
//  5 Timeout: model never raises end -> RECOVER after TIMEOUT+1 WAIT cycles, mul_rst_no low exactly 2 cycles,
//    err_o+done_o pulse, result_o=0; next request completes normally.
//  6 Reset mid-WAIT: assert rst_i -> no done_o; after release a new op on req 3 (0x0A*0xF6) gives 0xFF9C.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
//   MUL_W / RES_W : multiplier operand and product widths
//   WD_W          : watchdog counter width (covers TIMEOUT up to 255)
//   state_t       : sequencer state encoding
//   operands_t    : operand pair latched at grant
package booth_pkg;

    localparam int unsigned MUL_W = 8;
    localparam int unsigned RES_W = 16;
    localparam int unsigned WD_W  = 8;
    localparam int unsigned ST_W  = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t LOAD_Q  = 3'd1;
    localparam state_t LOAD_M  = 3'd2;
    localparam state_t WAIT    = 3'd3;
    localparam state_t DONE    = 3'd4;
    localparam state_t RECOVER = 3'd5;

    typedef struct packed {
        logic [MUL_W-1:0] q;
        logic [MUL_W-1:0] m;
    } operands_t;

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Requester and multiplier bus bundle for booth_mul_arbiter.
//   req_i/opa_i/opb_i      : requests and per-requester operands (8 bits per slice)
//   gnt_o/done_o           : one-hot owner and completion pulse
//   result_o/err_o         : product and timeout flag, valid with done_o
//   mul_*                  : shared multiplier bus (reset, begin, operand in, end, result out)
// slave is the arbiter side, master is the requester/multiplier side.
interface booth_mul_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import booth_pkg::*;

    logic [NREQ-1:0]       req_i;
    logic [MUL_W*NREQ-1:0] opa_i;
    logic [MUL_W*NREQ-1:0] opb_i;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ-1:0]       done_o;
    logic [RES_W-1:0]      result_o;
    logic                  err_o;
    logic                  mul_rst_no;
    logic                  mul_begin_o;
    logic [MUL_W-1:0]      mul_inbus_o;
    logic                  mul_end_i;
    logic [MUL_W-1:0]      mul_outbus_i;

    modport slave (
        input  req_i, opa_i, opb_i, mul_end_i, mul_outbus_i,
        output gnt_o, done_o, result_o, err_o, mul_rst_no, mul_begin_o, mul_inbus_o
    );

    modport master (
        output req_i, opa_i, opb_i, mul_end_i, mul_outbus_i,
        input  gnt_o, done_o, result_o, err_o, mul_rst_no, mul_begin_o, mul_inbus_o
    );

endinterface

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
//   req   : request vector
//   ptr   : priority start index (always < NREQ)
//   gnt   : one-hot winner, zero when no request
//   idx   : winner index
//   valid : at least one request present
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // ptr + off modulo NREQ; ptr < NREQ and off < NREQ so one subtract suffices.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] cand;

    // Scan from the pointer; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = wrap_add(ptr, i);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one 8x8 signed Booth multiplier among NREQ requesters.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active low
//   bus    : requester side (req/operands in, gnt/done/result/err out) and
//            multiplier side (mul_rst_no/begin/inbus out, end/outbus in)
// A granted op drives Q then M to the multiplier, collects the product
// (high byte one cycle before end, low byte with end) and returns it to the
// owner. A watchdog resets a hung multiplier and reports err_o.
module booth_mul_arbiter
    import booth_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    booth_mul_arbiter_if.slave    bus
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    operands_t        ops_q, ops_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [MUL_W-1:0] hi_q, hi_d;
    logic             rec_q, rec_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             mrst_q, mrst_d;
    logic             begin_q, begin_d;
    logic [MUL_W-1:0] inbus_q, inbus_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic             wd_expired;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (bus.req_i),
        .ptr   (rr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign wd_expired = (wd_q == WD_W'(TIMEOUT));

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = LOAD_Q;
            LOAD_Q:  state_d = LOAD_M;
            LOAD_M:  state_d = WAIT;
            WAIT: begin
                // End on the timeout cycle still counts as success.
                if (bus.mul_end_i) begin
                    state_d = DONE;
                end else if (wd_expired) begin
                    state_d = RECOVER;
                end
            end
            DONE:    state_d = IDLE;
            RECOVER: if (rec_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of all registered outputs and datapath state.
    always_comb begin
        rr_d     = rr_q;
        idx_d    = idx_q;
        ops_d    = ops_q;
        wd_d     = wd_q;
        hi_d     = hi_q;
        rec_d    = rec_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        result_d = result_q;
        err_d    = err_q;
        mrst_d   = mrst_q;
        begin_d  = begin_q;
        inbus_d  = inbus_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                    begin_d = 1'b1;
                    for (int unsigned k = 0; k < NREQ; k++) begin
                        if (arb_idx == IDX_W'(k)) begin
                            ops_d.q = bus.opa_i[k*MUL_W +: MUL_W];
                            ops_d.m = bus.opb_i[k*MUL_W +: MUL_W];
                            inbus_d = bus.opa_i[k*MUL_W +: MUL_W];
                        end
                    end
                end
            end
            LOAD_Q: begin
                begin_d = 1'b0;
                inbus_d = ops_q.m;
            end
            LOAD_M: begin
                wd_d = '0;
            end
            WAIT: begin
                // High byte arrives one cycle before end; keep the latest sample.
                hi_d = bus.mul_outbus_i;
                wd_d = WD_W'(wd_q + 1'b1);
                if (bus.mul_end_i) begin
                    result_d = {hi_q, bus.mul_outbus_i};
                    done_d   = gnt_q;
                    gnt_d    = '0;
                end else if (wd_expired) begin
                    mrst_d = 1'b0;
                    rec_d  = 1'b0;
                end
            end
            DONE: begin
                done_d = '0;
                err_d  = 1'b0;
                rr_d   = (idx_q == IDX_W'(NREQ - 1)) ? '0 : IDX_W'(idx_q + 1'b1);
            end
            RECOVER: begin
                // Two cycles of multiplier reset, then report through DONE.
                if (!rec_q) begin
                    rec_d = 1'b1;
                end else begin
                    mrst_d   = 1'b1;
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = gnt_q;
                    gnt_d    = '0;
                end
            end
            default: begin
                gnt_d   = '0;
                done_d  = '0;
                begin_d = 1'b0;
                mrst_d  = 1'b1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_q     <= '0;
            idx_q    <= '0;
            ops_q    <= '0;
            wd_q     <= '0;
            hi_q     <= '0;
            rec_q    <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            mrst_q   <= 1'b1;
            begin_q  <= 1'b0;
            inbus_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            idx_q    <= idx_d;
            ops_q    <= ops_d;
            wd_q     <= wd_d;
            hi_q     <= hi_d;
            rec_q    <= rec_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            mrst_q   <= mrst_d;
            begin_q  <= begin_d;
            inbus_q  <= inbus_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.done_o      = done_q;
    assign bus.result_o    = result_q;
    assign bus.err_o       = err_q;
    assign bus.mul_rst_no  = mrst_q;
    assign bus.mul_begin_o = begin_q;
    assign bus.mul_inbus_o = inbus_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a behavioural multiplier model.
module tb_booth_mul_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 31;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    booth_mul_arbiter_if #(.NREQ(NREQ)) bus_if ();

    booth_mul_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multiplier model: Q on begin, M next cycle, then mdl_lat idle cycles,
    // high byte, then low byte with end. mdl_hang never finishes.
    int               mdl_lat  = 0;
    bit               mdl_hang = 1'b0;
    int               stage    = 0;
    int               cnt      = 0;
    logic [7:0]       mq;
    logic [7:0]       mm;
    logic signed [15:0] prod;

    always @(negedge clk) begin
        if (!rst_n || !bus_if.mul_rst_no) begin
            stage               = 0;
            bus_if.mul_end_i    = 1'b0;
            bus_if.mul_outbus_i = 8'h00;
        end else begin
            case (stage)
                0: if (bus_if.mul_begin_o) begin
                    mq    = bus_if.mul_inbus_o;
                    stage = 1;
                end
                1: begin
                    mm    = bus_if.mul_inbus_o;
                    prod  = $signed(mq) * $signed(mm);
                    cnt   = mdl_lat;
                    stage = mdl_hang ? 5 : 2;
                end
                2: if (cnt != 0) begin
                    cnt = cnt - 1;
                end else begin
                    bus_if.mul_outbus_i = prod[15:8];
                    stage = 3;
                end
                3: begin
                    bus_if.mul_outbus_i = prod[7:0];
                    bus_if.mul_end_i    = 1'b1;
                    stage = 4;
                end
                4: begin
                    bus_if.mul_outbus_i = 8'h00;
                    bus_if.mul_end_i    = 1'b0;
                    stage = 0;
                end
                default: ;
            endcase
        end
    end

    // Background monitor.
    int done_cnt    = 0;
    int rst_low_cnt = 0;
    int onehot_viol = 0;

    always @(negedge clk) begin
        if (bus_if.done_o != 4'b0000) done_cnt++;
        if (!bus_if.mul_rst_no) rst_low_cnt++;
        if (rst_n && (!$onehot0(bus_if.gnt_o) || !$onehot0(bus_if.done_o))) onehot_viol++;
    end

    // Observe one op until done_o or the cycle budget runs out.
    task automatic run_until_done(input int max_cyc,
                                  output logic [3:0] g_seen, output logic [7:0] q_seen,
                                  output logic [7:0] m_seen, output logic beg_after,
                                  output logic [3:0] d_seen, output logic [15:0] r_seen,
                                  output logic e_seen, output int lat, output bit expired);
        bit got_g;
        bit got_q;
        int gcyc;
        int qcyc;
        g_seen = '0; q_seen = '0; m_seen = '0; beg_after = 1'b1;
        d_seen = '0; r_seen = '0; e_seen = 1'b0; lat = 0; expired = 1'b1;
        got_g = 1'b0; got_q = 1'b0; gcyc = 0; qcyc = 0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (!got_g && bus_if.gnt_o != 4'b0000) begin
                g_seen = bus_if.gnt_o; gcyc = cyc; got_g = 1'b1;
            end
            if (!got_q && bus_if.mul_begin_o) begin
                q_seen = bus_if.mul_inbus_o; qcyc = cyc; got_q = 1'b1;
            end else if (got_q && cyc == qcyc + 1) begin
                m_seen = bus_if.mul_inbus_o; beg_after = bus_if.mul_begin_o;
            end
            if (bus_if.done_o != 4'b0000) begin
                d_seen = bus_if.done_o; r_seen = bus_if.result_o; e_seen = bus_if.err_o;
                lat = cyc - gcyc; expired = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0]  g, d;
    logic [7:0]  q, m;
    logic        ba, e;
    logic [15:0] r;
    int          lat;
    bit          to;

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_if.req_i = 4'($urandom);
            bus_if.opa_i = $urandom;
            bus_if.opb_i = $urandom;
        end
        @(negedge clk);
        checks++; if (bus_if.gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", bus_if.gnt_o); end
        checks++; if (bus_if.done_o !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b expected 0000", bus_if.done_o); end
        checks++; if (bus_if.result_o !== 16'h0000) begin failures++; $display("FAIL reset_result: got %h expected 0000", bus_if.result_o); end
        checks++; if (bus_if.err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus_if.err_o); end
        checks++; if (bus_if.mul_begin_o !== 1'b0) begin failures++; $display("FAIL reset_begin: got %b expected 0", bus_if.mul_begin_o); end
        checks++; if (bus_if.mul_inbus_o !== 8'h00) begin failures++; $display("FAIL reset_inbus: got %h expected 00", bus_if.mul_inbus_o); end
        checks++; if (bus_if.mul_rst_no !== 1'b1) begin failures++; $display("FAIL reset_mul_rst_no: got %b expected 1", bus_if.mul_rst_no); end
        bus_if.req_i = '0;
        bus_if.opa_i = '0;
        bus_if.opb_i = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        mdl_lat = 2;
        @(negedge clk);
        bus_if.opa_i[15:8] = 8'hFD;
        bus_if.opb_i[15:8] = 8'h05;
        bus_if.req_i = 4'b0010;
        run_until_done(50, g, q, m, ba, d, r, e, lat, to);
        bus_if.req_i = 4'b0000;
        checks++; if (to) begin failures++; $display("FAIL single_timeout: got no done expected done within 50 cycles"); end
        checks++; if (g !== 4'b0010) begin failures++; $display("FAIL single_gnt: got %b expected 0010", g); end
        checks++; if (q !== 8'hFD) begin failures++; $display("FAIL single_q: got %h expected fd", q); end
        checks++; if (m !== 8'h05 || ba !== 1'b0) begin failures++; $display("FAIL single_m: got %h begin %b expected 05 begin 0", m, ba); end
        checks++; if (d !== 4'b0010) begin failures++; $display("FAIL single_done: got %b expected 0010", d); end
        checks++; if (r !== 16'hFFF1) begin failures++; $display("FAIL single_result: got %h expected fff1", r); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL single_err: got %b expected 0", e); end
        checks++; if (lat != 6) begin failures++; $display("FAIL single_latency: got %0d expected 6", lat); end
        repeat (3) @(negedge clk);
        checks++; if (bus_if.result_o !== 16'hFFF1 || bus_if.done_o !== 4'b0000) begin
            failures++; $display("FAIL single_hold: got result %h done %b expected fff1 0000", bus_if.result_o, bus_if.done_o);
        end
    endtask

    task automatic test_contention();
        do_reset();
        mdl_lat = 1;
        bus_if.opa_i[7:0]   = 8'h80; bus_if.opb_i[7:0]   = 8'h80;
        bus_if.opa_i[23:16] = 8'h7F; bus_if.opb_i[23:16] = 8'h02;
        bus_if.req_i = 4'b0101;
        run_until_done(50, g, q, m, ba, d, r, e, lat, to);
        bus_if.req_i = 4'b0100;
        checks++; if (to || g !== 4'b0001 || d !== 4'b0001) begin failures++; $display("FAIL cont_first_owner: got gnt %b done %b expired %0d expected 0001 0001", g, d, to); end
        checks++; if (r !== 16'h4000) begin failures++; $display("FAIL cont_first_result: got %h expected 4000", r); end
        run_until_done(50, g, q, m, ba, d, r, e, lat, to);
        bus_if.req_i = 4'b0000;
        checks++; if (to || g !== 4'b0100 || d !== 4'b0100) begin failures++; $display("FAIL cont_second_owner: got gnt %b done %b expired %0d expected 0100 0100", g, d, to); end
        checks++; if (r !== 16'h00FE) begin failures++; $display("FAIL cont_second_result: got %h expected 00fe", r); end
        checks++; if (onehot_viol != 0) begin failures++; $display("FAIL cont_onehot: got %0d violations expected 0", onehot_viol); end
    endtask

    task automatic test_wrap();
        logic [3:0]  exp_g [4];
        logic [15:0] exp_r [4];
        exp_g = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
        exp_r = '{16'h0001, 16'h0006, 16'h0001, 16'h0006};
        mdl_lat = 0;
        @(negedge clk);
        bus_if.opa_i[7:0]   = 8'h02; bus_if.opb_i[7:0]   = 8'h03;
        bus_if.opa_i[31:24] = 8'hFF; bus_if.opb_i[31:24] = 8'hFF;
        bus_if.req_i = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            run_until_done(50, g, q, m, ba, d, r, e, lat, to);
            checks++; if (to || g !== exp_g[i] || d !== exp_g[i]) begin
                failures++; $display("FAIL wrap_order_%0d: got gnt %b done %b expected %b", i, g, d, exp_g[i]);
            end
            checks++; if (r !== exp_r[i]) begin failures++; $display("FAIL wrap_result_%0d: got %h expected %h", i, r, exp_r[i]); end
        end
        bus_if.req_i = 4'b0000;
    endtask

    task automatic test_timeout();
        int rl0;
        mdl_hang = 1'b1;
        @(negedge clk);
        rl0 = rst_low_cnt;
        bus_if.opa_i[15:8] = 8'h11; bus_if.opb_i[15:8] = 8'h22;
        bus_if.req_i = 4'b0010;
        run_until_done(100, g, q, m, ba, d, r, e, lat, to);
        bus_if.req_i = 4'b0000;
        checks++; if (to || d !== 4'b0010) begin failures++; $display("FAIL tmo_done: got %b expired %0d expected 0010", d, to); end
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL tmo_err: got %b expected 1", e); end
        checks++; if (r !== 16'h0000) begin failures++; $display("FAIL tmo_result: got %h expected 0000", r); end
        checks++; if (lat != int'(TIMEOUT) + 5) begin failures++; $display("FAIL tmo_latency: got %0d expected %0d", lat, TIMEOUT + 5); end
        checks++; if (rst_low_cnt - rl0 != 2) begin failures++; $display("FAIL tmo_mul_rst_cycles: got %0d expected 2", rst_low_cnt - rl0); end
        @(negedge clk);
        checks++; if (bus_if.err_o !== 1'b0 || bus_if.done_o !== 4'b0000) begin
            failures++; $display("FAIL tmo_pulse_width: got err %b done %b expected 0 0000", bus_if.err_o, bus_if.done_o);
        end
        mdl_hang = 1'b0;
        bus_if.opa_i[23:16] = 8'h06; bus_if.opb_i[23:16] = 8'h07;
        bus_if.req_i = 4'b0100;
        run_until_done(50, g, q, m, ba, d, r, e, lat, to);
        bus_if.req_i = 4'b0000;
        checks++; if (to || d !== 4'b0100 || e !== 1'b0) begin failures++; $display("FAIL tmo_next_op: got done %b err %b expected 0100 0", d, e); end
        checks++; if (r !== 16'h002A) begin failures++; $display("FAIL tmo_next_result: got %h expected 002a", r); end
    endtask

    task automatic test_reset_mid();
        int dc0;
        mdl_lat = 20;
        @(negedge clk);
        bus_if.opa_i[7:0] = 8'h05; bus_if.opb_i[7:0] = 8'h05;
        bus_if.req_i = 4'b0001;
        repeat (6) @(negedge clk);
        dc0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus_if.gnt_o !== 4'b0000 || bus_if.mul_begin_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset_outputs: got gnt %b begin %b expected 0000 0", bus_if.gnt_o, bus_if.mul_begin_o);
        end
        bus_if.req_i = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++; if (done_cnt != dc0) begin failures++; $display("FAIL mid_no_done: got %0d done pulses expected 0", done_cnt - dc0); end
        mdl_lat = 0;
        bus_if.opa_i[31:24] = 8'h0A; bus_if.opb_i[31:24] = 8'hF6;
        bus_if.req_i = 4'b1000;
        run_until_done(50, g, q, m, ba, d, r, e, lat, to);
        bus_if.req_i = 4'b0000;
        checks++; if (to || d !== 4'b1000 || e !== 1'b0) begin failures++; $display("FAIL mid_next_op: got done %b err %b expected 1000 0", d, e); end
        checks++; if (r !== 16'hFF9C) begin failures++; $display("FAIL mid_next_result: got %h expected ff9c", r); end
        checks++; if (onehot_viol != 0) begin failures++; $display("FAIL final_onehot: got %0d violations expected 0", onehot_viol); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.req_i        = '0;
        bus_if.opa_i        = '0;
        bus_if.opb_i        = '0;
        bus_if.mul_end_i    = 1'b0;
        bus_if.mul_outbus_i = 8'h00;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
